// File: rtl/eth_pkg.sv
// Ethernet receive constants and FSM state type shared by the RX framer and CRC logic.
package eth_pkg;

   localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
   localparam logic [7:0]  ETH_SFD       = 8'hD5;
   localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PREAMBLE = 2'd1,
      ST_DATA     = 2'd2,
      ST_DROP     = 2'd3
   } rx_state_t;

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide CRC-32 step: reflected polynomial, data consumed LSB first.
// Purely combinational so the TX FCS inserter can reuse it unchanged.
module crc32_d8
   import eth_pkg::*;
(
   input  logic [31:0] i_crc,
   input  logic [7:0]  i_data,
   output logic [31:0] o_crc
);

   // Eight serial LFSR steps unrolled into one combinational cloud.
   always_comb begin
      o_crc = i_crc;
      for (int i = 0; i < 8; i++) begin
         if (o_crc[0] ^ i_data[i]) begin
            o_crc = (o_crc >> 1) ^ CRC32_POLY;
         end else begin
            o_crc = o_crc >> 1;
         end
      end
   end

endmodule

// File: rtl/gmii_rx_frame.sv
// GMII receive framer: validates and strips preamble/SFD, checks CRC-32 and
// strips the FCS using a 5-byte delay line, flags oversize and runt frames.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   ST_IDLE     | between frames, waiting for dv with a preamble byte
//   ST_PREAMBLE | counting 0x55 bytes, waiting for SFD
//   ST_DATA     | post-SFD bytes: delay line, CRC, byte count
//   ST_DROP     | bad preamble or oversize, ignore bytes until dv falls
module gmii_rx_frame
   import eth_pkg::*;
#(
   parameter int MAX_FRAME    = 1522,
   parameter int MIN_PREAMBLE = 1
) (
   input  logic       gmii_rx_clk,
   input  logic       rst,
   input  logic       gmii_rx_dv,
   input  logic [7:0] gmii_rxd,
   output logic       m_valid,
   output logic [7:0] m_data,
   output logic       m_sof,
   output logic       m_eof,
   output logic       m_err,
   output logic       frame_ok,
   output logic       frame_err
);

   localparam logic [15:0] LP_MAX_FRAME = 16'(MAX_FRAME);
   localparam logic [3:0]  LP_MIN_PRE   = 4'(MIN_PREAMBLE);
   localparam logic [15:0] LP_DLY_DEPTH = 16'd5;

   rx_state_t   r_state;
   rx_state_t   w_state_nxt;
   logic [3:0]  r_pre_cnt;
   logic [15:0] r_byte_cnt;
   logic [31:0] r_crc;
   logic [7:0]  r_dly [0:4];
   logic        r_sof_pend;

   logic [31:0] w_crc_nxt;
   logic        w_sfd;
   logic        w_oversize;
   logic        w_data_in;
   logic        w_end;
   logic        w_full;
   logic        w_crc_good;

   logic        w_valid_nxt;
   logic [7:0]  w_data_nxt;
   logic        w_sof_nxt;
   logic        w_eof_nxt;
   logic        w_err_nxt;
   logic        w_ok_nxt;
   logic        w_ferr_nxt;

   crc32_d8 u_crc (
      .i_crc  (r_crc),
      .i_data (gmii_rxd),
      .o_crc  (w_crc_nxt)
   );

   // Per-cycle frame events decoded from state and the incoming byte.
   always_comb begin
      w_sfd      = (r_state == ST_PREAMBLE) && gmii_rx_dv && (gmii_rxd == ETH_SFD)
                   && (r_pre_cnt >= LP_MIN_PRE);
      w_oversize = (r_state == ST_DATA) && gmii_rx_dv && (r_byte_cnt >= LP_MAX_FRAME);
      w_data_in  = (r_state == ST_DATA) && gmii_rx_dv && !w_oversize;
      w_end      = (r_state == ST_DATA) && !gmii_rx_dv;
      w_full     = (r_byte_cnt >= LP_DLY_DEPTH);
      w_crc_good = (r_crc == CRC32_RESIDUE);
   end

   // State register.
   always_ff @(posedge gmii_rx_clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (gmii_rx_dv) begin
               w_state_nxt = (gmii_rxd == ETH_PREAMBLE) ? ST_PREAMBLE : ST_DROP;
            end
         end
         ST_PREAMBLE: begin
            if (!gmii_rx_dv) begin
               w_state_nxt = ST_IDLE;
            end else if (gmii_rxd == ETH_PREAMBLE) begin
               w_state_nxt = ST_PREAMBLE;
            end else if (w_sfd) begin
               w_state_nxt = ST_DATA;
            end else begin
               w_state_nxt = ST_DROP;
            end
         end
         ST_DATA: begin
            if (!gmii_rx_dv) begin
               w_state_nxt = ST_IDLE;
            end else if (w_oversize) begin
               w_state_nxt = ST_DROP;
            end
         end
         ST_DROP: begin
            if (!gmii_rx_dv) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Output decode; every output is registered so data lags the delay line by one cycle.
   always_comb begin
      w_valid_nxt = w_full && (w_data_in || w_end || w_oversize);
      w_data_nxt  = w_valid_nxt ? r_dly[4] : m_data;
      w_sof_nxt   = w_valid_nxt && r_sof_pend;
      w_eof_nxt   = w_full && (w_end || w_oversize);
      w_err_nxt   = w_full && (w_oversize || (w_end && !w_crc_good));
      w_ok_nxt    = w_full && w_end && w_crc_good;
      w_ferr_nxt  = w_oversize || (w_end && (!w_full || !w_crc_good));
   end

   // Output registers.
   always_ff @(posedge gmii_rx_clk) begin
      if (rst) begin
         m_valid   <= 1'b0;
         m_data    <= 8'h00;
         m_sof     <= 1'b0;
         m_eof     <= 1'b0;
         m_err     <= 1'b0;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         m_valid   <= w_valid_nxt;
         m_data    <= w_data_nxt;
         m_sof     <= w_sof_nxt;
         m_eof     <= w_eof_nxt;
         m_err     <= w_err_nxt;
         frame_ok  <= w_ok_nxt;
         frame_err <= w_ferr_nxt;
      end
   end

   // Datapath: preamble count, delay line, CRC accumulation and byte count.
   always_ff @(posedge gmii_rx_clk) begin
      if (rst) begin
         r_pre_cnt  <= 4'd0;
         r_byte_cnt <= 16'd0;
         r_crc      <= CRC32_INIT;
         r_sof_pend <= 1'b0;
         for (int i = 0; i < 5; i++) begin
            r_dly[i] <= 8'h00;
         end
      end else begin
         if ((r_state == ST_IDLE) && gmii_rx_dv && (gmii_rxd == ETH_PREAMBLE)) begin
            r_pre_cnt <= 4'd1;
         end else if ((r_state == ST_PREAMBLE) && gmii_rx_dv && (gmii_rxd == ETH_PREAMBLE)
                      && (r_pre_cnt != 4'hF)) begin
            r_pre_cnt <= r_pre_cnt + 4'd1;
         end

         if (w_sfd) begin
            r_crc      <= CRC32_INIT;
            r_byte_cnt <= 16'd0;
            r_sof_pend <= 1'b1;
         end else if (w_data_in) begin
            r_crc    <= w_crc_nxt;
            r_dly[0] <= gmii_rxd;
            for (int i = 1; i < 5; i++) begin
               r_dly[i] <= r_dly[i-1];
            end
            if (r_byte_cnt != 16'hFFFF) begin
               r_byte_cnt <= r_byte_cnt + 16'd1;
            end
         end

         // SOF belongs to the first byte leaving the delay line only.
         if (w_valid_nxt) begin
            r_sof_pend <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_gmii_rx_frame.sv
// Directed bench for gmii_rx_frame: good, corrupted, bad-preamble, runt,
// oversize, single-byte and mid-frame-reset cases.
module tb_gmii_rx_frame;

   logic       clk;
   logic       rst;
   logic       dv;
   logic [7:0] rxd;
   logic       m_valid;
   logic [7:0] m_data;
   logic       m_sof;
   logic       m_eof;
   logic       m_err;
   logic       frame_ok;
   logic       frame_err;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] raw [0:1023];
   int         raw_len;
   logic [7:0] exp_b [0:255];
   int         exp_len;
   logic [7:0] cap [0:511];

   int n_valid, sof_cnt, eof_cnt, eof_err_cnt, ok_cnt, ferr_cnt, stray;
   int last_sof_idx, last_eof_idx;

   gmii_rx_frame #(
      .MAX_FRAME    (64),
      .MIN_PREAMBLE (1)
   ) dut (
      .gmii_rx_clk (clk),
      .rst         (rst),
      .gmii_rx_dv  (dv),
      .gmii_rxd    (rxd),
      .m_valid     (m_valid),
      .m_data      (m_data),
      .m_sof       (m_sof),
      .m_eof       (m_eof),
      .m_err       (m_err),
      .frame_ok    (frame_ok),
      .frame_err   (frame_err)
   );

   initial clk = 1'b0;
   always #4 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // Output monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (m_valid) begin
         if (n_valid < 512) cap[n_valid] = m_data;
         if (m_sof) begin sof_cnt++; last_sof_idx = n_valid; end
         if (m_eof) begin
            eof_cnt++;
            last_eof_idx = n_valid;
            if (m_err) eof_err_cnt++;
         end
         n_valid++;
      end else if (m_sof || m_eof) begin
         stray++;
      end
      if (m_err && !(m_valid && m_eof)) stray++;
      if (frame_ok)  ok_cnt++;
      if (frame_err) ferr_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_checks++;
      if (got !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
      end
   endtask

   task automatic clear_stats();
      n_valid = 0; sof_cnt = 0; eof_cnt = 0; eof_err_cnt = 0;
      ok_cnt = 0; ferr_cnt = 0; stray = 0;
      last_sof_idx = -1; last_eof_idx = -1;
   endtask

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
         else             r = r >> 1;
      end
      return r;
   endfunction

   function automatic int data_mism(input int n);
      int m;
      m = 0;
      for (int i = 0; i < n; i++) begin
         if (cap[i] !== exp_b[i % exp_len]) m++;
      end
      return m;
   endfunction

   // Build npre x 0x55, SFD, nb pattern bytes, optional FCS; optionally flip bit 0 of one payload byte.
   task automatic build_frame(input int npre, input int nb, input int seed,
                              input int flip, input bit add_fcs);
      logic [31:0] crc;
      logic [31:0] fcs;
      logic [7:0]  b;
      raw_len = 0;
      for (int i = 0; i < npre; i++) begin raw[raw_len] = 8'h55; raw_len++; end
      raw[raw_len] = 8'hD5; raw_len++;
      crc = 32'hFFFFFFFF;
      for (int i = 0; i < nb; i++) begin
         b = 8'((i * 13 + seed) & 255);
         crc = crc_byte(crc, b);
         if (i == flip) b = b ^ 8'h01;
         if (i < 256) exp_b[i] = b;
         raw[raw_len] = b; raw_len++;
      end
      exp_len = (nb < 256) ? nb : 256;
      if (add_fcs) begin
         fcs = ~crc;
         for (int k = 0; k < 4; k++) begin
            raw[raw_len] = fcs[8*k +: 8]; raw_len++;
         end
      end
   endtask

   task automatic drive(input logic v, input logic [7:0] d);
      @(negedge clk);
      dv  = v;
      rxd = d;
   endtask

   task automatic play(input int gap);
      for (int i = 0; i < raw_len; i++) drive(1'b1, raw[i]);
      for (int i = 0; i < gap; i++) drive(1'b0, 8'h00);
   endtask

   task automatic check_good(input string tag);
      chk({tag, "_nvalid"}, n_valid, 60);
      chk({tag, "_sof_idx"}, last_sof_idx, 0);
      chk({tag, "_eof_idx"}, last_eof_idx, 59);
      chk({tag, "_eof_err"}, eof_err_cnt, 0);
      chk({tag, "_ok"}, ok_cnt, 1);
      chk({tag, "_ferr"}, ferr_cnt, 0);
      chk({tag, "_data"}, data_mism(60), 0);
      chk({tag, "_stray"}, stray, 0);
   endtask

   initial begin
      rst = 1'b1; dv = 1'b0; rxd = 8'h00;
      clear_stats();
      repeat (4) @(negedge clk);
      chk("reset_outs", {m_valid, m_sof, m_eof, m_err, frame_ok, frame_err, m_data}, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Good 60-byte frame, exactly MAX_FRAME post-SFD bytes.
      clear_stats();
      build_frame(7, 60, 3, -1, 1'b1);
      play(6);
      check_good("good");

      // Two identical frames with a single idle cycle between them.
      clear_stats();
      play(1);
      play(6);
      chk("b2b_nvalid", n_valid, 120);
      chk("b2b_sof", sof_cnt, 2);
      chk("b2b_eof", eof_cnt, 2);
      chk("b2b_ok", ok_cnt, 2);
      chk("b2b_ferr", ferr_cnt, 0);
      chk("b2b_data", data_mism(120), 0);

      // Payload byte 20 bit 0 flipped after the FCS was computed.
      clear_stats();
      build_frame(7, 60, 3, 19, 1'b1);
      play(6);
      chk("crc_nvalid", n_valid, 60);
      chk("crc_eof_idx", last_eof_idx, 59);
      chk("crc_eof_err", eof_err_cnt, 1);
      chk("crc_ok", ok_cnt, 0);
      chk("crc_ferr", ferr_cnt, 1);
      chk("crc_data", data_mism(60), 0);

      // Corrupt preamble 55 55 54 followed by 60 bytes: silently dropped.
      clear_stats();
      build_frame(2, 60, 5, -1, 1'b1);
      raw[2] = 8'h54;
      play(4);
      chk("badpre_nvalid", n_valid, 0);
      chk("badpre_pulses", ok_cnt + ferr_cnt, 0);
      clear_stats();
      build_frame(7, 60, 9, -1, 1'b1);
      play(6);
      check_good("after_badpre");

      // Minimum preamble with a runt of 3 bytes.
      clear_stats();
      build_frame(1, 3, 7, -1, 1'b0);
      play(4);
      chk("runt_nvalid", n_valid, 0);
      chk("runt_ferr", ferr_cnt, 1);
      chk("runt_ok", ok_cnt, 0);
      chk("runt_stray", stray, 0);

      // Minimum preamble with a full frame is accepted.
      clear_stats();
      build_frame(1, 60, 11, -1, 1'b1);
      play(6);
      check_good("minpre");

      // Oversize: 100 post-SFD bytes against MAX_FRAME=64.
      clear_stats();
      build_frame(7, 100, 2, -1, 1'b0);
      play(8);
      chk("over_nvalid", n_valid, 60);
      chk("over_eof_idx", last_eof_idx, 59);
      chk("over_eof_cnt", eof_cnt, 1);
      chk("over_eof_err", eof_err_cnt, 1);
      chk("over_ferr", ferr_cnt, 1);
      chk("over_ok", ok_cnt, 0);
      chk("over_data", data_mism(60), 0);

      // Single-byte frame: one byte carrying both SOF and EOF.
      clear_stats();
      build_frame(7, 1, 4, -1, 1'b1);
      play(5);
      chk("one_nvalid", n_valid, 1);
      chk("one_sof_eof", {sof_cnt[3:0], eof_cnt[3:0]}, 8'h11);
      chk("one_idx", {last_sof_idx[3:0], last_eof_idx[3:0]}, 8'h00);
      chk("one_ok", ok_cnt, 1);
      chk("one_data", data_mism(1), 0);

      // Reset for one cycle at post-SFD byte 30.
      clear_stats();
      build_frame(7, 60, 1, -1, 1'b1);
      for (int i = 0; i < raw_len; i++) begin
         @(negedge clk);
         if (i == 38) begin
            chk("rst_mid_outs",
                {m_valid, m_sof, m_eof, m_err, frame_ok, frame_err, m_data}, 0);
         end
         dv  = 1'b1;
         rxd = raw[i];
         rst = (i == 37);
      end
      @(negedge clk); dv = 1'b0; rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst_mid_nvalid", n_valid, 24);
      chk("rst_mid_eof", eof_cnt, 0);
      chk("rst_mid_pulses", ok_cnt + ferr_cnt, 0);
      clear_stats();
      build_frame(7, 60, 3, -1, 1'b1);
      play(6);
      check_good("after_rst");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
